// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 byte values, default key scancodes and the prefix
// state type shared by the key tracker and its prefix decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_OVR0     = 8'h00;
    localparam logic [7:0] PS2_OVR1     = 8'hFF;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_I = 8'h43;
    localparam logic [7:0] KEY_K = 8'h42;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } prefix_state_t;

    // Keyboard self-test results and overrun markers drop every held key.
    function automatic logic is_flush(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_BAT_FAIL) ||
               (b == PS2_OVR0)   || (b == PS2_OVR1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// ps2_prefix_fsm: decodes E0/F0 prefixes into one key event per byte.
// Define PS2_KEY_TRACKER_TIMEOUT_EN to abandon stale prefixes.
module ps2_prefix_fsm
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_tick,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    output logic       ev_ext,
    output logic       ev_make,
    output logic [7:0] ev_code,
    output logic       ev_flush,
    output logic       ev_err
);

    prefix_state_t state;
    prefix_state_t state_nxt;
    logic          timeout;

`ifdef PS2_KEY_TRACKER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || rx_tick || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = !rx_tick && (state != ST_IDLE) &&
                     (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_tick) begin
            unique case (1'b1)
                rx_data == PS2_EXT: state_nxt = ST_EXT;
                rx_data == PS2_BRK: state_nxt = (state == ST_EXT) ?
                                                ST_EXT_BRK : ST_BRK;
                default:            state_nxt = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = ST_IDLE;
        end
    end

    logic in_brk;

    assign in_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

    always_comb begin
        ev_valid = 1'b0;
        ev_flush = 1'b0;
        ev_err   = timeout;
        ev_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_make  = (state == ST_IDLE) || (state == ST_EXT);
        ev_code  = rx_data;
        if (rx_tick) begin
            unique case (1'b1)
                is_prefix(rx_data): ev_err = in_brk;
                (state == ST_IDLE) && is_flush(rx_data): ev_flush = 1'b1;
                default: ev_valid = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: held/press/release tracking for a table of PS/2 keys.
// Define PS2_KEY_TRACKER_TIMEOUT_EN to enable the prefix timeout.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                    N_KEYS      = 4,
    parameter logic [N_KEYS*9-1:0]   KEY_CODES   = {9'h0_42, 9'h0_43,
                                                    9'h0_1B, 9'h0_1D},
    parameter int                    TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_tick,
    input  logic [7:0]        rx_data,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              seq_error
);

    logic       ev_valid;
    logic       ev_ext;
    logic       ev_make;
    logic [7:0] ev_code;
    logic       ev_flush;
    logic       ev_err;

    ps2_prefix_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .rx_tick  (rx_tick),
        .rx_data  (rx_data),
        .ev_valid (ev_valid),
        .ev_ext   (ev_ext),
        .ev_make  (ev_make),
        .ev_code  (ev_code),
        .ev_flush (ev_flush),
        .ev_err   (ev_err)
    );

    logic [N_KEYS-1:0] hit;
    logic [N_KEYS-1:0] down_nxt;

    // Duplicate table entries simply light several hit bits at once.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_match
        assign hit[i] = ev_valid &&
                        (KEY_CODES[9*i +: 9] == {ev_ext, ev_code});
        assign down_nxt[i] = ev_flush ? 1'b0 :
                             hit[i]   ? ev_make : key_down[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_down    <= '0;
            key_press   <= '0;
            key_release <= '0;
            seq_error   <= 1'b0;
        end else begin
            key_down    <= down_nxt;
            key_press   <= down_nxt & ~key_down;
            key_release <= key_down & ~down_nxt;
            seq_error   <= ev_err;
        end
    end

endmodule
